// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the traffic light monitor.
//   phase_t       - decoded lamp phase (R, RY, G, Y)
//   mon_st_t      - monitor FSM states
//   ERR_*         - err_code values
//   DEF_*_CYC     - default required dwell per phase
//   next_phase()  - the single legal successor of a phase
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_R  = 2'd0,
      PH_RY = 2'd1,
      PH_G  = 2'd2,
      PH_Y  = 2'd3
   } phase_t;

   typedef enum logic {
      ST_SYNC  = 1'b0,
      ST_TRACK = 1'b1
   } mon_st_t;

   localparam logic [1:0] ERR_ILLEGAL_ENC = 2'd0;
   localparam logic [1:0] ERR_BAD_TRANS   = 2'd1;
   localparam logic [1:0] ERR_EARLY       = 2'd2;
   localparam logic [1:0] ERR_LATE        = 2'd3;

   localparam int DEF_R_CYC  = 3;
   localparam int DEF_RY_CYC = 1;
   localparam int DEF_G_CYC  = 2;
   localparam int DEF_Y_CYC  = 2;

   // The phase order R -> RY -> G -> Y -> R matches the encoding order,
   // so the successor is just the 2-bit increment with wrap.
   function automatic phase_t next_phase(input phase_t p);
      return phase_t'(p + 2'd1);
   endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: lamp bus plus monitor status.
//   master: drives en, lamps (red/yellow/green), clr_err; reads status
//   slave : the monitor; reads lamps/controls, drives phase, locked, dwell,
//           err, err_code, err_sticky, cycle_cnt
interface traffic_light_monitor_if
   import traffic_pkg::*;
#(
   parameter int DW_W  = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic             red;
   logic             yellow;
   logic             green;
   logic             clr_err;
   phase_t           phase;
   logic             locked;
   logic [DW_W-1:0]  dwell;
   logic             err;
   logic [1:0]       err_code;
   logic             err_sticky;
   logic [CNT_W-1:0] cycle_cnt;

   modport master (
      output en, red, yellow, green, clr_err,
      input  phase, locked, dwell, err, err_code, err_sticky, cycle_cnt
   );

   modport slave (
      input  en, red, yellow, green, clr_err,
      output phase, locked, dwell, err, err_code, err_sticky, cycle_cnt
   );
endinterface

// File: rtl/traffic_lamp_decode.sv
// traffic_lamp_decode: combinational lamp code decoder.
//   r, y, g : lamp lines
//   legal   : code is one of R(100), RY(110), G(001), Y(010)
//   ph      : decoded phase (R when illegal; ignore unless legal)
module traffic_lamp_decode
   import traffic_pkg::*;
(
   input  logic   r,
   input  logic   y,
   input  logic   g,
   output logic   legal,
   output phase_t ph
);
   always_comb begin
      legal = 1'b1;
      ph    = PH_R;
      case ({r, y, g})
         3'b100:  ph = PH_R;
         3'b110:  ph = PH_RY;
         3'b001:  ph = PH_G;
         3'b010:  ph = PH_Y;
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: receive-side checker for a 3-lamp traffic light.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): en, red/yellow/green, clr_err in;
//                phase, locked, dwell, err, err_code, err_sticky, cycle_cnt out
// SYNC waits for a legal phase transition, TRACK checks order and dwell of
// every sample. Any error drops back to SYNC.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int R_CYC  = DEF_R_CYC,
   parameter int RY_CYC = DEF_RY_CYC,
   parameter int G_CYC  = DEF_G_CYC,
   parameter int Y_CYC  = DEF_Y_CYC,
   parameter int DW_W   = 4,
   parameter int CNT_W  = 8
)(
   input  logic clk,
   input  logic rst_n,
   traffic_light_monitor_if.slave bus
);

   function automatic logic [DW_W-1:0] req_dwell(input phase_t p);
      case (p)
         PH_R:    return DW_W'(R_CYC);
         PH_RY:   return DW_W'(RY_CYC);
         PH_G:    return DW_W'(G_CYC);
         default: return DW_W'(Y_CYC);
      endcase
   endfunction

   logic   legal;
   phase_t ph;

   traffic_lamp_decode u_dec (
      .r     (bus.red),
      .y     (bus.yellow),
      .g     (bus.green),
      .legal (legal),
      .ph    (ph)
   );

   mon_st_t          st, st_d;
   logic             prev_vld, prev_vld_d;  // phase register holds a usable previous sample
   phase_t           phase, phase_d;
   logic             locked, locked_d;
   logic [DW_W-1:0]  dwell, dwell_d, dw_inc;
   logic             err, err_d;
   logic [1:0]       err_code, err_code_d;
   logic             err_sticky, err_sticky_d;
   logic [CNT_W-1:0] cycle_cnt, cycle_cnt_d;
   logic             fault;
   logic [1:0]       fcode;

   assign dw_inc = (dwell == {DW_W{1'b1}}) ? dwell : dwell + 1'b1;

   always_comb begin
      st_d         = st;
      prev_vld_d   = prev_vld;
      phase_d      = phase;
      locked_d     = locked;
      dwell_d      = dwell;
      err_d        = 1'b0;
      err_code_d   = err_code;
      err_sticky_d = bus.clr_err ? 1'b0 : err_sticky;
      cycle_cnt_d  = cycle_cnt;
      fault        = 1'b0;
      fcode        = ERR_ILLEGAL_ENC;

      if (bus.en) begin
         case (st)
            ST_SYNC: begin
               // phase doubles as the stored previous sample
               if (legal) begin
                  phase_d    = ph;
                  prev_vld_d = 1'b1;
                  if (prev_vld && ph != phase && next_phase(phase) == ph) begin
                     st_d     = ST_TRACK;
                     locked_d = 1'b1;
                     dwell_d  = {{(DW_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  prev_vld_d = 1'b0;
               end
            end
            default: begin
               // Only one branch can fire per sample, so the priority
               // order of the error causes falls out of the if-chain.
               if (!legal) begin
                  fault = 1'b1;
                  fcode = ERR_ILLEGAL_ENC;
               end else if (ph == phase) begin
                  if (dw_inc > req_dwell(phase)) begin
                     fault = 1'b1;
                     fcode = ERR_LATE;
                  end else begin
                     dwell_d = dw_inc;
                  end
               end else if (next_phase(phase) == ph) begin
                  if (dwell < req_dwell(phase)) begin
                     fault = 1'b1;
                     fcode = ERR_EARLY;
                  end else begin
                     dwell_d = {{(DW_W-1){1'b0}}, 1'b1};
                     phase_d = ph;
                     if (phase == PH_R) cycle_cnt_d = cycle_cnt + 1'b1;
                  end
               end else begin
                  fault = 1'b1;
                  fcode = ERR_BAD_TRANS;
               end
            end
         endcase

         // An error overrides clr_err and restarts the sync search, keeping
         // the offending sample as the new previous phase when it is legal.
         if (fault) begin
            err_d        = 1'b1;
            err_code_d   = fcode;
            err_sticky_d = 1'b1;
            st_d         = ST_SYNC;
            locked_d     = 1'b0;
            dwell_d      = '0;
            phase_d      = legal ? ph : phase;
            prev_vld_d   = legal;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= ST_SYNC;
         prev_vld   <= 1'b0;
         phase      <= PH_R;
         locked     <= 1'b0;
         dwell      <= '0;
         err        <= 1'b0;
         err_code   <= ERR_ILLEGAL_ENC;
         err_sticky <= 1'b0;
         cycle_cnt  <= '0;
      end else begin
         st         <= st_d;
         prev_vld   <= prev_vld_d;
         phase      <= phase_d;
         locked     <= locked_d;
         dwell      <= dwell_d;
         err        <= err_d;
         err_code   <= err_code_d;
         err_sticky <= err_sticky_d;
         cycle_cnt  <= cycle_cnt_d;
      end
   end

   assign bus.phase      = phase;
   assign bus.locked     = locked;
   assign bus.dwell      = dwell;
   assign bus.err        = err;
   assign bus.err_code   = err_code;
   assign bus.err_sticky = err_sticky;
   assign bus.cycle_cnt  = cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed self-checking bench for the monitor.
module tb_traffic_light_monitor;
   import traffic_pkg::*;

   localparam logic [2:0] L_R   = 3'b100;
   localparam logic [2:0] L_RY  = 3'b110;
   localparam logic [2:0] L_G   = 3'b001;
   localparam logic [2:0] L_Y   = 3'b010;
   localparam logic [2:0] L_BAD = 3'b111;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   traffic_light_monitor_if #(.DW_W(4), .CNT_W(8)) bus ();

   traffic_light_monitor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply a lamp code away from the edge, then sample just after the edge.
   task automatic smp(input logic [2:0] rgy);
      {bus.red, bus.yellow, bus.green} = rgy;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_st(input string tag, input logic [1:0] ph, input logic lk,
                         input logic [3:0] dw, input logic e);
      chk({tag, ".phase"},  32'(bus.phase),  32'(ph));
      chk({tag, ".locked"}, 32'(bus.locked), 32'(lk));
      chk({tag, ".dwell"},  32'(bus.dwell),  32'(dw));
      chk({tag, ".err"},    32'(bus.err),    32'(e));
   endtask

   task automatic chk_err(input string tag, input logic [1:0] code, input logic [1:0] ph);
      chk({tag, ".err"},      32'(bus.err),        32'd1);
      chk({tag, ".code"},     32'(bus.err_code),   32'(code));
      chk({tag, ".sticky"},   32'(bus.err_sticky), 32'd1);
      chk({tag, ".locked"},   32'(bus.locked),     32'd0);
      chk({tag, ".dwell"},    32'(bus.dwell),      32'd0);
      chk({tag, ".phase"},    32'(bus.phase),      32'(ph));
   endtask

   initial begin
      logic [2:0] seq [8];
      seq[0] = L_RY; seq[1] = L_G; seq[2] = L_G; seq[3] = L_Y;
      seq[4] = L_Y;  seq[5] = L_R; seq[6] = L_R; seq[7] = L_R;

      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.clr_err = 1'b0;
      {bus.red, bus.yellow, bus.green} = L_R;
      repeat (2) @(posedge clk);
      #1;
      // reset state
      chk_st("rst", 2'd0, 1'b0, 4'd0, 1'b0);
      chk("rst.code",   32'(bus.err_code),   32'd0);
      chk("rst.sticky", 32'(bus.err_sticky), 32'd0);
      chk("rst.cnt",    32'(bus.cycle_cnt),  32'd0);

      // nominal: 3 periods RY,G,G,Y,Y,R,R,R
      rst_n = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         smp(seq[(i-1) % 8]);
         chk("nom.err", 32'(bus.err), 32'd0);
         if (i == 1) chk("nom1.locked", 32'(bus.locked), 32'd0);
         if (i == 2) chk_st("nom2", 2'd2, 1'b1, 4'd1, 1'b0);
         if (i == 17) chk("nom17.cnt", 32'(bus.cycle_cnt), 32'd2);
      end
      chk_st("nom24", 2'd0, 1'b1, 4'd3, 1'b0);
      chk("nom24.cnt", 32'(bus.cycle_cnt), 32'd2);

      // illegal code while locked; phase holds at R
      smp(L_BAD);
      chk_err("ill", ERR_ILLEGAL_ENC, 2'd0);
      smp(L_R);                              // previous was invalid: stays in SYNC
      chk_st("ill.r", 2'd0, 1'b0, 4'd0, 1'b0);
      chk("ill.sticky", 32'(bus.err_sticky), 32'd1);
      smp(L_RY);                             // relock
      chk_st("ill.relock", 2'd1, 1'b1, 4'd1, 1'b0);
      smp(L_G);
      smp(L_G);
      chk_st("trk.g2", 2'd2, 1'b1, 4'd2, 1'b0);

      // G -> R is out of order
      smp(L_R);
      chk_err("bad", ERR_BAD_TRANS, 2'd0);
      smp(L_RY);
      chk_st("bad.relock", 2'd1, 1'b1, 4'd1, 1'b0);
      smp(L_G);
      smp(L_G);
      smp(L_Y);
      chk_st("early.y1", 2'd3, 1'b1, 4'd1, 1'b0);
      smp(L_R);                              // Y only 1 of 2 cycles
      chk_err("early", ERR_EARLY, 2'd0);

      // G held 3 cycles
      smp(L_RY);
      smp(L_G);
      smp(L_G);
      chk_st("late.g2", 2'd2, 1'b1, 4'd2, 1'b0);
      smp(L_G);
      chk_err("late", ERR_LATE, 2'd2);

      // clr_err coinciding with an EARLY error: error wins
      smp(L_Y);                              // relock from G
      chk_st("prio.y1", 2'd3, 1'b1, 4'd1, 1'b0);
      bus.clr_err = 1'b1;
      smp(L_R);
      chk_err("prio", ERR_EARLY, 2'd0);
      smp(L_R);                              // clr_err alone
      chk("clr.sticky", 32'(bus.err_sticky), 32'd0);
      chk("clr.err",    32'(bus.err),        32'd0);
      bus.clr_err = 1'b0;

      // en low for 5 cycles mid-G: no LATE, everything holds
      smp(L_RY);
      smp(L_G);
      smp(L_G);
      bus.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         smp(L_G);
         chk_st("en0", 2'd2, 1'b1, 4'd2, 1'b0);
      end
      chk("en0.sticky", 32'(bus.err_sticky), 32'd0);
      bus.en = 1'b1;
      smp(L_Y);
      chk_st("en1.y", 2'd3, 1'b1, 4'd1, 1'b0);

      // async reset between clock edges
      #3;
      rst_n = 1'b0;
      #1;
      chk_st("arst", 2'd0, 1'b0, 4'd0, 1'b0);
      chk("arst.cnt", 32'(bus.cycle_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      smp(L_RY);
      chk("arst.s1.locked", 32'(bus.locked), 32'd0);
      smp(L_G);
      chk_st("arst.s2", 2'd2, 1'b1, 4'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the 3-lamp traffic light controller. It samples the red/yellow/green lamp lines every clock and decodes them into a phase. It locks onto the phase sequence, measures how long each phase lasts, and flags illegal lamp codes, illegal phase orders and wrong phase lengths. It sits beside the light controller in the testbench/top level as an independent consumer of the lamp bus.

## Interface
Parameters:
- R_CYC, 3, required dwell of phase R, in sampled cycles
- RY_CYC, 1, required dwell of phase RY
- G_CYC, 2, required dwell of phase G
- Y_CYC, 2, required dwell of phase Y
- DW_W, 4, dwell counter width; must hold max(*_CYC)+1
- CNT_W, 8, cycle counter width

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  sample enable; low = hold all state, no checks
- red, yellow, green  in  1 each  lamp lines
- clr_err  in  1  clears err_sticky
- phase  out  2  decoded phase of the last legal sample: R=0, RY=1, G=2, Y=3
- locked  out  1  monitor is tracking the sequence
- dwell  out  DW_W  consecutive enabled cycles in the current phase (1 = first cycle)
- err  out  1  one-cycle error pulse
- err_code  out  2  cause of the last error: ILLEGAL_ENC=0, BAD_TRANS=1, EARLY=2, LATE=3
- err_sticky  out  1  set by err, cleared by clr_err
- cycle_cnt  out  CNT_W  completed periods; wraps modulo 2^CNT_W

## Operation
- Legal lamp codes (r,y,g): 100=R, 110=RY, 001=G, 010=Y. All other codes are ILLEGAL_ENC.
- Legal successors:
  - R→R or RY
  - RY→RY or G
  - G→G or Y
  - Y→Y or R
- The FSM has two states, SYNC and TRACK.
- SYNC:
  - Each legal sample updates phase and the stored previous phase.
  - Enter TRACK when a sample is the legal successor of a different, legal previous sample. On entry, locked=1 and dwell=1.
  - No errors are raised in SYNC. An illegal code only invalidates the stored previous phase.
- TRACK, on each enabled sample:
  - Illegal code → ILLEGAL_ENC.
  - Same phase → dwell+1. If the new dwell exceeds the phase's *_CYC → LATE.
  - Legal successor → if the old dwell < the old phase's *_CYC → EARLY. Otherwise dwell=1 and phase updates. An R→RY transition increments cycle_cnt.
  - Any other phase → BAD_TRANS.
- On any error:
  - err=1 for one cycle, err_code is loaded, err_sticky=1.
  - FSM → SYNC, locked=0, dwell=0.
  - phase takes the new sample if it is legal, otherwise it holds.
  - Errors raised in the same sample are prioritised ILLEGAL_ENC > BAD_TRANS > EARLY > LATE.
- Once in SYNC after an error, the monitor relocks on the next legal transition.
- clr_err in the same cycle as a new error: the error wins and err_sticky stays 1.
- en=0: outputs hold, except err, which returns to 0. clr_err is still honoured.
- Widths: dwell saturates at 2^DW_W−1. cycle_cnt wraps silently.

## Timing
- All outputs are registered. Values after posedge k reflect the lamps sampled at posedge k, with no extra input stage.
- Reset values: phase=R(0), locked=0, dwell=0, err=0, err_code=0, err_sticky=0, cycle_cnt=0, FSM=SYNC, previous phase invalid.
- Reset asserted mid-sequence clears everything immediately, without waiting for a clock edge. The first posedge after release is treated as the first sample.
- err is high for exactly the cycle after the offending edge.

## Structure
- Shared package traffic_pkg holds:
  - the phase enum
  - the err_code constants
  - a next_phase function
  - default dwell constants (3/1/2/2)
- One combinational sub-module, traffic_lamp_decode, maps (r,y,g) → {legal, phase}. The FSM, counters and error logic live in traffic_light_monitor.

## Test plan
- Nominal: after reset, drive the repeating lamp sequence RY,G,G,Y,Y,R,R,R for 3 periods.
  - locked=1 after the 2nd edge (phase=G, dwell=1).
  - err is never asserted.
  - cycle_cnt=2 after edge 17.
- Illegal code while locked: drive 111 for one sample.
  - err=1 with err_code=0, err_sticky=1, locked=0.
  - Relocks on the next legal transition.
- Order and dwell violations, one error each, locked=0 after each:
  - G→R: err_code=1 (BAD_TRANS).
  - Y held for 1 cycle then R: err_code=2 (EARLY).
  - G held for 3 cycles: err_code=3 (LATE) on the 3rd G sample.
- Priority and clr_err: assert clr_err on the same edge as an EARLY error.
  - err_sticky stays 1.
  - clr_err on the next edge alone → err_sticky=0.
- en and reset:
  - en=0 for 5 cycles mid-G: dwell, phase and locked hold, and no LATE is raised.
  - Asserting rst_n=0 between clock edges clears all outputs immediately.
